// File: rtl/rv32i_ctrl_pipe_pkg.sv
// Shared rv32i types for the in-flight control pipe: control word, pipe entry and the register-match rule.
// The forwarding option of rv32i_ctrl_pipe is selected with RV32I_CTRL_PIPE_FWD_EN.
package rv32i_types;

  typedef logic [31:0] rv32i_word;
  typedef logic [4:0]  rv32i_reg;

  localparam rv32i_reg RV32I_X0 = 5'd0;

  typedef enum logic [6:0] {
    op_lui   = 7'b0110111,
    op_auipc = 7'b0010111,
    op_jal   = 7'b1101111,
    op_jalr  = 7'b1100111,
    op_br    = 7'b1100011,
    op_load  = 7'b0000011,
    op_store = 7'b0100011,
    op_imm   = 7'b0010011,
    op_reg   = 7'b0110011,
    op_csr   = 7'b1110011
  } rv32i_opcode;

  typedef struct packed {
    rv32i_opcode opcode;
    logic [2:0]  funct3;
    logic        load_regfile;
    rv32i_reg    dest_reg;
    logic        mem_read;
    logic        mem_write;
  } rv32i_ctrl_word;

  typedef struct packed {
    logic           v;
    logic           rdy;
    rv32i_ctrl_word ctrl;
    rv32i_word      data;
  } rv32i_pipe_entry_t;

  // x0 is hardwired, so an in-flight write to it never produces a dependency.
  function automatic logic reg_match(logic v, logic load, rv32i_reg dest, rv32i_reg rs);
    return v && load && (dest == rs) && (rs != RV32I_X0);
  endfunction

endpackage

// File: rtl/rv32i_ctrl_pipe_fwd_match.sv
// Youngest-match priority selector for one decode source register.
// A match on a stage that is not ready reports a stall instead of a hit.
module rv32i_fwd_match
  import rv32i_types::*;
#(
  parameter int DEPTH = 3,
  parameter int XLEN  = 32
) (
  input  logic [DEPTH-1:0]           valid,
  input  logic [DEPTH-1:0]           load,
  input  logic [DEPTH-1:0]           rdy,
  input  logic [DEPTH-1:0][4:0]      dest,
  input  logic [DEPTH-1:0][XLEN-1:0] data,
  input  logic [4:0]                 rs,
  output logic                       hit,
  output logic                       stall,
  output logic [XLEN-1:0]            fwd_data
);

  logic            found;
  logic            sel_rdy;
  logic [XLEN-1:0] sel_data;

  // NOTE: combinational blocks use blocking assignments and give every output a default first,
  // so no latch is inferred and the last assignment in program order wins.
  always_comb begin
    found    = 1'b0;
    sel_rdy  = 1'b0;
    sel_data = '0;
    // Scan oldest to youngest so the lowest matching index overrides the rest.
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (reg_match(valid[i], load[i], dest[i], rs)) begin
        found    = 1'b1;
        sel_rdy  = rdy[i];
        sel_data = data[i];
      end
    end
  end

  assign hit      = found && sel_rdy;
  assign stall    = found && !sel_rdy;
  assign fwd_data = hit ? sel_data : '0;

endmodule

// File: rtl/rv32i_ctrl_pipe.sv
// In-flight instruction tracker between decode and writeback: stage shifting, result capture and
// forwarding/hazard answers for decode. Define RV32I_CTRL_PIPE_FWD_EN to enable forwarding.
module rv32i_ctrl_pipe
  import rv32i_types::*;
#(
  parameter int DEPTH       = 3,
  parameter int XLEN        = 32,
  parameter int FLUSH_DEPTH = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  rv32i_ctrl_word              in_ctrl,
  output logic                        in_ready,
  input  logic                        hold,
  input  logic                        flush,
  input  logic                        res_wr,
  input  logic [$clog2(DEPTH)-1:0]    res_idx,
  input  logic [XLEN-1:0]             res_data,
  input  logic [4:0]                  rs1_q,
  input  logic [4:0]                  rs2_q,
  output logic                        fwd1_hit,
  output logic [XLEN-1:0]             fwd1_data,
  output logic                        fwd2_hit,
  output logic [XLEN-1:0]             fwd2_data,
  output logic                        hazard,
  output logic [DEPTH-1:0]            stage_valid,
  output rv32i_ctrl_word [DEPTH-1:0]  stage_ctrl,
  output logic [DEPTH-1:0][XLEN-1:0]  stage_data,
  output logic                        retire_valid,
  output rv32i_ctrl_word              retire_ctrl,
  output logic [XLEN-1:0]             retire_data
);

  localparam int IW = $clog2(DEPTH);

  rv32i_pipe_entry_t [DEPTH-1:0] pipe;
  rv32i_pipe_entry_t [DEPTH-1:0] pipe_wr;
  rv32i_pipe_entry_t [DEPTH-1:0] pipe_nxt;

  logic [DEPTH-1:0]      st_load;
  logic [DEPTH-1:0]      fwd_rdy;
  logic [DEPTH-1:0][4:0] st_dest;
  logic                  stall1;
  logic                  stall2;
  logic                  wr_hit;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      stage_valid[i] = pipe[i].v;
      stage_ctrl[i]  = pipe[i].ctrl;
      stage_data[i]  = XLEN'(pipe[i].data);
      st_load[i]     = pipe[i].ctrl.load_regfile;
      st_dest[i]     = pipe[i].ctrl.dest_reg;
    end
  end

`ifdef RV32I_CTRL_PIPE_FWD_EN
  always_comb begin
    for (int i = 0; i < DEPTH; i++) fwd_rdy[i] = pipe[i].rdy;
  end
`else
  // Presenting every match as not-ready stalls decode until the producer has retired.
  assign fwd_rdy = '0;
`endif

  rv32i_fwd_match #(.DEPTH(DEPTH), .XLEN(XLEN)) u_match_rs1 (
    .valid    (stage_valid),
    .load     (st_load),
    .rdy      (fwd_rdy),
    .dest     (st_dest),
    .data     (stage_data),
    .rs       (rs1_q),
    .hit      (fwd1_hit),
    .stall    (stall1),
    .fwd_data (fwd1_data)
  );

  rv32i_fwd_match #(.DEPTH(DEPTH), .XLEN(XLEN)) u_match_rs2 (
    .valid    (stage_valid),
    .load     (st_load),
    .rdy      (fwd_rdy),
    .dest     (st_dest),
    .data     (stage_data),
    .rs       (rs2_q),
    .hit      (fwd2_hit),
    .stall    (stall2),
    .fwd_data (fwd2_data)
  );

  assign hazard   = in_valid && (stall1 || stall2);
  assign in_ready = !hold && !hazard;

  // Writes aimed at an empty stage (or past the last stage) are dropped.
  assign wr_hit = res_wr && (int'(res_idx) < DEPTH) && pipe[res_idx].v;

  assign retire_valid = !hold && pipe[DEPTH-1].v;
  assign retire_ctrl  = pipe[DEPTH-1].ctrl;
  assign retire_data  = (wr_hit && res_idx == IW'(DEPTH - 1)) ? res_data
                                                               : XLEN'(pipe[DEPTH-1].data);

  always_comb begin
    pipe_wr = pipe;
    if (wr_hit) begin
      pipe_wr[res_idx].rdy  = 1'b1;
      pipe_wr[res_idx].data = rv32i_word'(res_data);
    end
  end

  always_comb begin
    pipe_nxt = pipe_wr;
    if (!hold) begin
      for (int i = DEPTH - 1; i >= 1; i--) pipe_nxt[i] = pipe_wr[i-1];
      pipe_nxt[0] = '0;
      if (in_valid && !hazard) begin
        pipe_nxt[0].v    = 1'b1;
        pipe_nxt[0].ctrl = in_ctrl;
      end
    end
    // Squashed stages become clean bubbles, which also discards a result written into them.
    if (flush) begin
      for (int i = 0; i < FLUSH_DEPTH; i++) pipe_nxt[i] = '0;
    end
  end

  // NOTE: state updates use non-blocking assignments; the whole entry array is small control
  // state, so it is reset in full rather than only the valid bits.
  always_ff @(posedge clk) begin
    if (rst) pipe <= '0;
    else     pipe <= pipe_nxt;
  end

endmodule

// File: tb/tb_rv32i_ctrl_pipe.sv
// Self-checking bench for rv32i_ctrl_pipe: a queue-based model checked every cycle plus directed
// literal expectations. Follows RV32I_CTRL_PIPE_FWD_EN the same way the design does.
module tb_rv32i_ctrl_pipe;
  import rv32i_types::*;

  localparam int DEPTH       = 3;
  localparam int XLEN        = 32;
  localparam int FLUSH_DEPTH = 1;
  localparam int IW          = $clog2(DEPTH);
`ifdef RV32I_CTRL_PIPE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic                       clk;
  logic                       rst;
  logic                       in_valid;
  rv32i_ctrl_word             in_ctrl;
  logic                       in_ready;
  logic                       hold;
  logic                       flush;
  logic                       res_wr;
  logic [IW-1:0]              res_idx;
  logic [XLEN-1:0]            res_data;
  logic [4:0]                 rs1_q;
  logic [4:0]                 rs2_q;
  logic                       fwd1_hit;
  logic [XLEN-1:0]            fwd1_data;
  logic                       fwd2_hit;
  logic [XLEN-1:0]            fwd2_data;
  logic                       hazard;
  logic [DEPTH-1:0]           stage_valid;
  rv32i_ctrl_word [DEPTH-1:0] stage_ctrl;
  logic [DEPTH-1:0][XLEN-1:0] stage_data;
  logic                       retire_valid;
  rv32i_ctrl_word             retire_ctrl;
  logic [XLEN-1:0]            retire_data;

  rv32i_ctrl_pipe #(.DEPTH(DEPTH), .XLEN(XLEN), .FLUSH_DEPTH(FLUSH_DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ctrl      (in_ctrl),
    .in_ready     (in_ready),
    .hold         (hold),
    .flush        (flush),
    .res_wr       (res_wr),
    .res_idx      (res_idx),
    .res_data     (res_data),
    .rs1_q        (rs1_q),
    .rs2_q        (rs2_q),
    .fwd1_hit     (fwd1_hit),
    .fwd1_data    (fwd1_data),
    .fwd2_hit     (fwd2_hit),
    .fwd2_data    (fwd2_data),
    .hazard       (hazard),
    .stage_valid  (stage_valid),
    .stage_ctrl   (stage_ctrl),
    .stage_data   (stage_data),
    .retire_valid (retire_valid),
    .retire_ctrl  (retire_ctrl),
    .retire_data  (retire_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  // Model: queue index 0 is the youngest stage.
  typedef struct packed {
    bit             v;
    bit             rdy;
    rv32i_ctrl_word c;
    logic [31:0]    d;
  } ment_t;

  ment_t m[$];
  bit    model_ok = 1'b0;

  function automatic void query(input logic [4:0] rs, output bit hit, output logic [31:0] d,
                                output bit stall);
    hit = 1'b0; d = '0; stall = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (m[i].v && m[i].c.load_regfile && m[i].c.dest_reg == rs && rs != 5'd0) begin
        if (FWD && m[i].rdy) begin
          hit = 1'b1;
          d   = m[i].d;
        end else begin
          stall = 1'b1;
        end
        return;
      end
    end
  endfunction

  always @(posedge clk) begin
    bit          h1, h2, s1, s2, accept;
    logic [31:0] d1, d2;
    ment_t       n;
    if (rst) begin
      m.delete();
      for (int i = 0; i < DEPTH; i++) m.push_back('0);
      model_ok = 1'b1;
    end else if (model_ok) begin
      query(rs1_q, h1, d1, s1);
      query(rs2_q, h2, d2, s2);
      accept = in_valid && !(s1 || s2);
      if (res_wr && int'(res_idx) < DEPTH && m[res_idx].v) begin
        m[res_idx].rdy = 1'b1;
        m[res_idx].d   = res_data;
      end
      if (!hold) begin
        n = '0;
        if (accept) begin
          n.v = 1'b1;
          n.c = in_ctrl;
        end
        m.push_front(n);
        void'(m.pop_back());
      end
      if (flush) for (int i = 0; i < FLUSH_DEPTH; i++) m[i] = '0;
    end
  end

  always @(negedge clk) begin
    bit          h1, h2, s1, s2, hz, rv;
    logic [31:0] d1, d2, rd;
    if (model_ok) begin
      query(rs1_q, h1, d1, s1);
      query(rs2_q, h2, d2, s2);
      hz = in_valid && (s1 || s2);
      check("m_fwd1_hit", fwd1_hit, h1);
      check("m_fwd1_data", fwd1_data, d1);
      check("m_fwd2_hit", fwd2_hit, h2);
      check("m_fwd2_data", fwd2_data, d2);
      check("m_hazard", hazard, hz);
      check("m_in_ready", in_ready, !hold && !hz);
      rv = !hold && m[DEPTH-1].v;
      check("m_retire_valid", retire_valid, rv);
      if (rv) begin
        rd = (res_wr && int'(res_idx) == DEPTH - 1) ? res_data : m[DEPTH-1].d;
        check("m_retire_ctrl", retire_ctrl, m[DEPTH-1].c);
        check("m_retire_data", retire_data, rd);
      end
      for (int i = 0; i < DEPTH; i++) begin
        check($sformatf("m_stage_valid[%0d]", i), stage_valid[i], m[i].v);
        if (m[i].v) begin
          check($sformatf("m_stage_ctrl[%0d]", i), stage_ctrl[i], m[i].c);
          check($sformatf("m_stage_data[%0d]", i), stage_data[i], m[i].d);
        end
      end
    end
  end

  function automatic rv32i_ctrl_word mk(input rv32i_opcode op, input logic [4:0] rd);
    rv32i_ctrl_word r;
    r = '0;
    r.opcode       = op;
    r.dest_reg     = rd;
    r.load_regfile = (op != op_store) && (op != op_br);
    r.mem_read     = (op == op_load);
    r.mem_write    = (op == op_store);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0; in_ctrl = '0; hold = 1'b0; flush = 1'b0;
    res_wr = 1'b0; res_idx = '0; res_data = '0; rs1_q = '0; rs2_q = '0;
  endtask

  task automatic issue(input rv32i_ctrl_word c);
    in_valid = 1'b1;
    in_ctrl  = c;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic write_res(input int idx, input logic [31:0] d, input bit hold_it);
    hold = hold_it; res_wr = 1'b1; res_idx = IW'(idx); res_data = d;
    tick();
    hold = 1'b0; res_wr = 1'b0;
  endtask

  // Waits out decode stalls with a bound; the number of stalled cycles is the checked value.
  task automatic wait_ready(input string name, input int exp_cycles);
    int cnt = 0;
    while (!in_ready && cnt < 10) begin
      cnt++;
      tick();
    end
    check(name, cnt, exp_cycles);
  endtask

  task automatic drain();
    idle();
    repeat (DEPTH + 1) tick();
  endtask

  initial begin
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("rst_stage_valid", stage_valid, 0);
    check("rst_hazard", hazard, 0);
    check("rst_retire_valid", retire_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_fwd1_hit", fwd1_hit, 0);

    // Basic flow: a write to x0 in flight, then addi x5 made ready with 0x10 under hold.
    issue(mk(op_imm, 5'd0));
    issue(mk(op_imm, 5'd5));
    write_res(0, 32'h10, 1'b1);
    in_valid = 1'b1; in_ctrl = mk(op_reg, 5'd6); rs1_q = 5'd0; rs2_q = 5'd0;
    #1;
    check("x0_fwd1_hit", fwd1_hit, 0);
    check("x0_hazard", hazard, 0);
    rs1_q = 5'd5; rs2_q = 5'd5;
    #1;
    if (FWD) begin
      check("basic_fwd1_hit", fwd1_hit, 1);
      check("basic_fwd2_hit", fwd2_hit, 1);
      check("basic_fwd1_data", fwd1_data, 32'h10);
      check("basic_fwd2_data", fwd2_data, 32'h10);
    end else begin
      check("basic_nofwd_hazard", hazard, 1);
      check("basic_nofwd_hit", fwd1_hit, 0);
    end
    wait_ready("basic_stall_cycles", FWD ? 0 : 3);
    tick();
    drain();

    // Load-use: lw x7 is not ready when add x8,x7 is queried.
    issue(mk(op_load, 5'd7));
    in_valid = 1'b1; in_ctrl = mk(op_reg, 5'd8); rs1_q = 5'd7;
    #1;
    check("lu_hazard", hazard, 1);
    check("lu_in_ready", in_ready, 0);
    tick();
    check("lu_bubble_valid", stage_valid, 3'b010);
    res_wr = 1'b1; res_idx = IW'(1); res_data = 32'hDEAD;
    #1;
    check("lu_hazard_on_write", hazard, 1);
    tick();
    res_wr = 1'b0;
    #1;
    if (FWD) begin
      check("lu_fwd1_hit", fwd1_hit, 1);
      check("lu_fwd1_data", fwd1_data, 32'hDEAD);
    end else begin
      check("lu_nofwd_hazard", hazard, 1);
    end
    check("lu_retire_valid", retire_valid, 1);
    check("lu_retire_data", retire_data, 32'hDEAD);
    wait_ready("lu_stall_cycles", FWD ? 0 : 1);
    tick();
    drain();

    // Youngest match: x3 ready in stage 2 (0x1) and stage 0 (0x2); x9 in stage 1 not ready.
    issue(mk(op_imm, 5'd3));
    write_res(0, 32'h1, 1'b1);
    issue(mk(op_imm, 5'd9));
    issue(mk(op_imm, 5'd3));
    check("ym_stage_valid", stage_valid, 3'b111);
    write_res(0, 32'h2, 1'b1);
    hold = 1'b1; in_valid = 1'b1; in_ctrl = mk(op_reg, 5'd10); rs1_q = 5'd3; rs2_q = 5'd9;
    #1;
    if (FWD) begin
      check("ym_fwd1_hit", fwd1_hit, 1);
      check("ym_fwd1_data", fwd1_data, 32'h2);
      check("ym_fwd2_hit", fwd2_hit, 0);
    end else begin
      check("ym_nofwd_hit", fwd1_hit, 0);
    end
    check("ym_hazard", hazard, 1);
    check("ym_in_ready", in_ready, 0);

    // Flush under hold, with a competing result write into the squashed stage.
    in_valid = 1'b0; rs1_q = '0; rs2_q = '0;
    flush = 1'b1; res_wr = 1'b1; res_idx = IW'(0); res_data = 32'h55;
    #1;
    check("fl_retire_valid", retire_valid, 0);
    tick();
    idle();
    #1;
    check("fl_stage_valid", stage_valid, 3'b110);
    res_wr = 1'b1; res_idx = IW'(DEPTH - 1); res_data = 32'h77;
    #1;
    check("fl_retire_valid_after", retire_valid, 1);
    check("fl_retire_bypass", retire_data, 32'h77);
    check("fl_retire_ctrl", retire_ctrl, mk(op_imm, 5'd3));
    tick();
    drain();

    // Mid-stream reset with hold and a result write pending.
    issue(mk(op_imm, 5'd3));
    issue(mk(op_imm, 5'd4));
    rst = 1'b1; hold = 1'b1; res_wr = 1'b1; res_idx = IW'(0); res_data = 32'hAA;
    in_valid = 1'b1; in_ctrl = mk(op_imm, 5'd5);
    tick();
    rst = 1'b0; hold = 1'b0; res_wr = 1'b0;
    in_ctrl = mk(op_reg, 5'd11); rs1_q = 5'd3; rs2_q = 5'd4;
    #1;
    check("mrst_stage_valid", stage_valid, 0);
    check("mrst_hazard", hazard, 0);
    check("mrst_retire_valid", retire_valid, 0);
    check("mrst_in_ready", in_ready, 1);
    idle();
    tick();

    // Mixed directed traffic on a small register set; the per-cycle model judges every output.
    for (int k = 0; k < 80; k++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_ctrl  = mk(($urandom_range(0, 4) == 0) ? op_store : op_imm, 5'($urandom_range(0, 3)));
      rs1_q    = 5'($urandom_range(0, 3));
      rs2_q    = 5'($urandom_range(0, 3));
      hold     = ($urandom_range(0, 4) == 0);
      flush    = ($urandom_range(0, 9) == 0);
      res_wr   = ($urandom_range(0, 1) == 1);
      res_idx  = IW'($urandom_range(0, (1 << IW) - 1));
      res_data = $urandom;
      tick();
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
